// File: rtl/calc_io_pkg.sv
// -----------------------------------------------------------------------------
// calc_io_pkg
// Shared definitions for the calculator SoC key-reader peripheral:
//   - Avalon word addresses of the four registers (DATA/STATUS/CONTROL/LIVE)
//   - bit positions inside STATUS and CONTROL
//   - key_event_t, the FIFO entry (switch snapshot + key index)
//   - pack_data(), which formats a FIFO entry as a DATA read word
// -----------------------------------------------------------------------------
package calc_io_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_LIVE    = 2'd3;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int CTRL_OVFCLR_BIT = 2;

    typedef struct packed {
        logic [15:0] sw;
        logic [2:0]  idx;
    } key_event_t;

    // DATA word: valid flag in bit 31, switch snapshot in [19:4], key index in [2:0]
    function automatic logic [31:0] pack_data(input key_event_t ev);
        return {1'b1, 11'h000, ev.sw, 1'b0, ev.idx};
    endfunction

endpackage

// File: rtl/calc_key_debounce.sv
// -----------------------------------------------------------------------------
// calc_key_debounce
// Single-bit debouncer. On every shared tick the (already synchronised) input
// is shifted into a SAMPLES-deep history; the output level only changes when
// the whole history, including the newest sample, agrees on the other level.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high; loads RST_LEVEL into history/output
//   i_tick   in   one-cycle sample strobe from the parent prescaler
//   i_din    in   synchronised raw input
//   o_level  out  debounced level
// SAMPLES must be at least 2.
// -----------------------------------------------------------------------------
module calc_key_debounce #(
    parameter int   SAMPLES   = 4,
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_din,
    output logic o_level
);

    logic [SAMPLES-1:0] r_hist;
    logic               r_level;
    logic [SAMPLES-1:0] w_hist_next;
    logic               w_all_hi;
    logic               w_all_lo;

    // History after this tick's sample and its agreement flags
    always_comb begin
        w_hist_next = {r_hist[SAMPLES-2:0], i_din};
        w_all_hi    = &w_hist_next;
        w_all_lo    = ~|w_hist_next;
    end

    // Sample history and accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist  <= {SAMPLES{RST_LEVEL}};
            r_level <= RST_LEVEL;
        end else if (i_tick) begin
            r_hist <= w_hist_next;
            if (w_all_hi) begin
                r_level <= 1'b1;
            end else if (w_all_lo) begin
                r_level <= 1'b0;
            end else begin
                r_level <= r_level;
            end
        end else begin
            r_hist  <= r_hist;
            r_level <= r_level;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/calc_key_reader.sv
// -----------------------------------------------------------------------------
// calc_key_reader
// Avalon-MM slave input peripheral: synchronises and debounces the board
// pushbuttons (active-low) and slide switches, turns each debounced press into
// a key event {switch snapshot, key index} and queues it in a FIFO that the
// HPS drains by reading DATA.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   keys_n     in   raw pushbuttons, 0 = pressed (asynchronous)
//   sw         in   raw slide switches (asynchronous)
//   address    in   register word address (DATA/STATUS/CONTROL/LIVE)
//   read       in   Avalon read strobe
//   write      in   Avalon write strobe
//   writedata  in   write data
//   readdata   out  read data, fixed read latency 1, zero when not reading
//   irq        out  level interrupt IE & ~EMPTY (only with CALC_KEY_IRQ_EN)
// Build option: define CALC_KEY_IRQ_EN to add the irq port and a writable
// CONTROL.IE; otherwise IE reads 0 and software polls STATUS.EMPTY.
// -----------------------------------------------------------------------------
module calc_key_reader
    import calc_io_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int NUM_SW     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 250000,
    parameter int SAMPLES    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic [NUM_SW-1:0]   sw,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata
`ifdef CALC_KEY_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // ---------------- synchronisers and prescaler ----------------
    logic [NUM_KEYS-1:0] r_keys_meta;
    logic [NUM_KEYS-1:0] r_keys_sync;
    logic [NUM_SW-1:0]   r_sw_meta;
    logic [NUM_SW-1:0]   r_sw_sync;
    logic [TICK_W-1:0]   r_presc;
    logic                w_tick;

    // Two-flop synchronisers; keys idle released (high), switches idle low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys_meta <= {NUM_KEYS{1'b1}};
            r_keys_sync <= {NUM_KEYS{1'b1}};
            r_sw_meta   <= {NUM_SW{1'b0}};
            r_sw_sync   <= {NUM_SW{1'b0}};
        end else begin
            r_keys_meta <= keys_n;
            r_keys_sync <= r_keys_meta;
            r_sw_meta   <= sw;
            r_sw_sync   <= r_sw_meta;
        end
    end

    assign w_tick = (r_presc == TICK_W'(TICK_DIV - 1));

    // Debounce sample prescaler, one tick every TICK_DIV clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= {TICK_W{1'b0}};
        end else if (w_tick) begin
            r_presc <= {TICK_W{1'b0}};
        end else begin
            r_presc <= r_presc + TICK_W'(1);
        end
    end

    // ---------------- debouncers ----------------
    logic [NUM_KEYS-1:0] w_keys_n_deb;
    logic [NUM_SW-1:0]   w_sw_deb;

    for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : g_key_deb
        calc_key_debounce #(.SAMPLES(SAMPLES), .RST_LEVEL(1'b1)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_tick  (w_tick),
            .i_din   (r_keys_sync[gk]),
            .o_level (w_keys_n_deb[gk])
        );
    end

    for (genvar gs = 0; gs < NUM_SW; gs++) begin : g_sw_deb
        calc_key_debounce #(.SAMPLES(SAMPLES), .RST_LEVEL(1'b0)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_tick  (w_tick),
            .i_din   (r_sw_sync[gs]),
            .o_level (w_sw_deb[gs])
        );
    end

    logic [NUM_KEYS-1:0] w_keys_pressed;
    logic [NUM_KEYS-1:0] r_keys_pressed_d;
    logic [NUM_KEYS-1:0] w_press_edge;
    logic [15:0]         w_sw16;
    logic [7:0]          w_keys8;

    assign w_keys_pressed = ~w_keys_n_deb;
    assign w_press_edge   = w_keys_pressed & ~r_keys_pressed_d;

    // Zero-extend debounced inputs to their register field widths
    always_comb begin
        w_sw16                  = 16'h0000;
        w_sw16[NUM_SW-1:0]      = w_sw_deb;
        w_keys8                 = 8'h00;
        w_keys8[NUM_KEYS-1:0]   = w_keys_pressed;
    end

    // Previous debounced key state for press-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys_pressed_d <= {NUM_KEYS{1'b0}};
        end else begin
            r_keys_pressed_d <= w_keys_pressed;
        end
    end

    // ---------------- register decode ----------------
    logic w_wr_ctrl;
    logic w_flush;
    logic w_ovf_clr;
    logic w_rd_data;
    logic w_unused_wdata;

    assign w_wr_ctrl      = write && (address == ADDR_CONTROL);
    assign w_flush        = w_wr_ctrl && writedata[CTRL_FLUSH_BIT];
    assign w_ovf_clr      = w_wr_ctrl && writedata[CTRL_OVFCLR_BIT];
    assign w_rd_data      = read && (address == ADDR_DATA);
    assign w_unused_wdata = ^{writedata[31:3], writedata[CTRL_IE_BIT]};

    // ---------------- pending arbiter ----------------
    logic [NUM_KEYS-1:0] r_pend;
    logic [NUM_KEYS-1:0] w_grant;
    logic [2:0]          w_grant_idx;
    logic                w_push_req;
    key_event_t          w_event;

    // Lowest-numbered pending key wins; scanning downward leaves the lowest
    always_comb begin
        w_grant_idx = 3'd0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_grant_idx = 3'(k);
            end else begin
                w_grant_idx = w_grant_idx;
            end
        end
        w_push_req  = |r_pend;
        w_grant     = w_push_req ? (NUM_KEYS'(1) << w_grant_idx) : {NUM_KEYS{1'b0}};
        w_event.sw  = w_sw16;
        w_event.idx = w_grant_idx;
    end

    // Pending press flags: granted bit clears, new press edges set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= {NUM_KEYS{1'b0}};
        end else if (w_flush) begin
            r_pend <= {NUM_KEYS{1'b0}};
        end else begin
            r_pend <= (r_pend & ~w_grant) | w_press_edge;
        end
    end

    // ---------------- event FIFO ----------------
    key_event_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;

    assign w_empty   = (r_count == CNT_W'(0));
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = w_rd_data && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives
    assign w_push_ok = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_drop    = w_push_req && !w_flush && w_full && !w_pop;

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_event;
        end
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle push/pop
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a new drop outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    // ---------------- interrupt enable / irq ----------------
    logic w_ie;

`ifdef CALC_KEY_IRQ_EN
    logic r_ie;
    logic r_irq;

    // Interrupt enable loaded by every CONTROL write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_ie <= writedata[CTRL_IE_BIT];
        end else begin
            r_ie <= r_ie;
        end
    end

    // Registered interrupt, follows IE & ~EMPTY one cycle late
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ie & ~w_empty;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
`endif

    // ---------------- read mux ----------------
    logic [31:0] w_rdata_next;
    logic [31:0] r_readdata;

    // Next read word; zero whenever no read is in progress
    always_comb begin
        w_rdata_next = 32'h0000_0000;
        if (read) begin
            case (address)
                ADDR_DATA:    w_rdata_next = w_empty ? 32'h0000_0000 : pack_data(r_mem[r_rd_ptr]);
                ADDR_STATUS:  w_rdata_next = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};
                ADDR_CONTROL: w_rdata_next = {30'h0000_0000, w_ie, 1'b0};
                ADDR_LIVE:    w_rdata_next = {w_sw16, 8'h00, w_keys8};
                default:      w_rdata_next = 32'h0000_0000;
            endcase
        end else begin
            w_rdata_next = 32'h0000_0000;
        end
    end

    // Registered read data, latency one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'h0000_0000;
        end else begin
            r_readdata <= w_rdata_next;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_calc_key_reader.sv
// -----------------------------------------------------------------------------
// tb_calc_key_reader
// Stimulus issues register reads and pushes the expected read word into a
// scoreboard queue; a monitor pops and compares each word one cycle after the
// read strobe. Expected values come from a transaction-level model: a queue of
// pending DATA words, an overflow flag, IE, and the settled key/switch levels.
// Inputs are only read back once they have had time to debounce.
// DATA layout: bit31 valid, switch snapshot [19:4], key index [2:0].
// -----------------------------------------------------------------------------
module tb_calc_key_reader;

    localparam int NK = 4;
    localparam int NS = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys_n = 4'hF;
    logic [NS-1:0] sw = 10'h000;
    logic [1:0]    address = 2'd0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = 32'h0;
    logic [31:0]   readdata;
`ifdef CALC_KEY_IRQ_EN
    logic          irq;
`endif

    calc_key_reader #(.NUM_KEYS(NK), .NUM_SW(NS), .FIFO_DEPTH(DEPTH), .TICK_DIV(4), .SAMPLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .keys_n    (keys_n),
        .sw        (sw),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata)
`ifdef CALC_KEY_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_vld = 1'b0;

    // reference model state
    logic [31:0] m_fifo[$];
    logic        m_ovf = 1'b0;
    logic        m_ie  = 1'b0;
    logic [NK-1:0] m_keys = 4'h0;
    logic [NS-1:0] m_sw   = 10'h000;

    always @(posedge clk) rd_vld <= read;

    // monitor: compare every read response against the scoreboard head
    always @(negedge clk) begin
        if (rd_vld) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got %08h, no expected value queued", readdata);
            end else begin
                logic [31:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (readdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %08h expected %08h", nm, readdata, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic settle();
        repeat (48) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input string nm);
        logic [31:0] e;
        case (a)
            2'd0: e = (m_fifo.size() > 0) ? m_fifo.pop_front() : 32'h0;
            2'd1: e = {16'h0, 8'(m_fifo.size()), 5'b0, m_ovf, (m_fifo.size() == DEPTH), (m_fifo.size() == 0)};
            2'd2: e = {30'h0, m_ie, 1'b0};
            default: e = {6'h0, m_sw, 8'h00, 4'h0, m_keys};
        endcase
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        read = 1'b1; address = a;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [2:0] v);
        @(negedge clk);
        write = 1'b1; address = 2'd2; writedata = {29'h0, v};
        @(negedge clk);
        write = 1'b0; writedata = 32'h0;
        if (v[0]) m_fifo.delete();
        if (v[2]) m_ovf = 1'b0;
`ifdef CALC_KEY_IRQ_EN
        m_ie = v[1];
`endif
    endtask

    task automatic set_sw(input logic [NS-1:0] v);
        sw = v; m_sw = v;
        settle();
    endtask

    // each newly pressed key queues one event, lowest index first
    task automatic set_keys(input logic [NK-1:0] p);
        for (int i = 0; i < NK; i++) begin
            if (p[i] && !m_keys[i]) begin
                if (m_fifo.size() < DEPTH)
                    m_fifo.push_back({1'b1, 11'h0, 6'h0, m_sw, 1'b0, 3'(i)});
                else
                    m_ovf = 1'b1;
            end
        end
        m_keys = p;
        keys_n = ~p;
        settle();
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_fifo.delete(); m_ovf = 1'b0; m_ie = 1'b0;
        settle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_readdata", readdata, 32'h0);
        rd(2'd1, "reset_status");
        rd(2'd0, "reset_data_empty");
        rd(2'd2, "reset_control");
        rd(2'd3, "reset_live");

        // single press with switch snapshot
        set_sw(10'h005);
        set_keys(4'b0100);
        rd(2'd3, "live_key2");
        rd(2'd0, "data_key2");
        rd(2'd1, "status_after_pop");
        set_keys(4'b0000);

        // overflow: nine presses of key0 into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            set_keys(4'b0001);
            set_keys(4'b0000);
        end
        rd(2'd1, "status_ovf");
        wr_ctrl(3'b100);
        rd(2'd1, "status_ovf_cleared");
        for (int i = 0; i < DEPTH; i++) rd(2'd0, "drain_data");
        rd(2'd1, "status_drained");
        rd(2'd0, "data_after_drain");

        // glitch shorter than the debounce window
        @(negedge clk); keys_n[1] = 1'b0;
        repeat (8) @(negedge clk);
        keys_n[1] = 1'b1;
        settle();
        rd(2'd3, "live_glitch");
        rd(2'd1, "status_glitch");

        // two keys in the same tick: lowest index first
        set_sw(10'h000);
        set_keys(4'b1001);
        rd(2'd0, "same_tick_first");
        rd(2'd0, "same_tick_second");
        set_keys(4'b0000);

`ifdef CALC_KEY_IRQ_EN
        wr_ctrl(3'b010);
        rd(2'd2, "control_ie");
        set_keys(4'b0010);
        chk("irq_set", {31'h0, irq}, 32'h1);
        rd(2'd0, "irq_data");
        chk("irq_still_high", {31'h0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        set_keys(4'b0000);
        for (int i = 0; i < 3; i++) begin
            set_keys(4'b0001);
            set_keys(4'b0000);
        end
        rd(2'd1, "status_count3");
        wr_ctrl(3'b001);
        rd(2'd1, "status_flushed");
        repeat (2) @(negedge clk);
        chk("irq_after_flush", {31'h0, irq}, 32'h0);
`else
        wr_ctrl(3'b010);
        rd(2'd2, "control_ie_ignored");
`endif

        // reset mid-operation discards queued events
        set_sw(10'h2A5);
        set_keys(4'b0110);
        set_keys(4'b0000);
        do_reset();
        rd(2'd1, "status_after_reset");
        rd(2'd0, "data_after_reset");
        rd(2'd3, "live_after_reset");

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0: set_sw(10'($urandom));
                1, 2: set_keys(4'($urandom));
                3: rd(2'd0, "rand_data");
                4: rd(2'd1, "rand_status");
                5: rd(2'd3, "rand_live");
                default: begin
                    wr_ctrl(3'($urandom) & 3'b110 | (($urandom_range(0, 3) == 0) ? 3'b001 : 3'b000));
                    rd(2'd2, "rand_control");
                end
            endcase
        end
        while (m_fifo.size() > 0) rd(2'd0, "final_drain");
        rd(2'd1, "final_status");

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
